// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
// req is held high until the matching one-cycle ack and is then dropped.
interface dff_bank_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic           clr;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           q_valid;
    logic           busy;

    modport master (output req, data, clr, input gnt, ack, q, q_valid, busy);
    modport slave  (input req, data, clr, output gnt, ack, q, q_valid, busy);
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that loads one requester's data into a shared W-bit
// register per IDLE -> LOAD -> ACK sequence, with a synchronous clear.
module dff_bank_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    dff_bank_arbiter_if.slave    bus,
    output logic [1:0]           state_dbg
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   sel, sel_n;
    logic [N-1:0]    gnt, gnt_n;
    logic [N-1:0]    ack, ack_n;
    logic [W-1:0]    q, q_n;
    logic            q_valid, q_valid_n;

    logic            found;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   cand;

    // Circular search for the first active request starting at ptr.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr) + i) % N);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        sel_n     = sel;
        gnt_n     = gnt;
        ack_n     = ack;
        q_n       = q;
        q_valid_n = q_valid;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (found) begin
                    sel_n        = pick;
                    gnt_n[pick]  = 1'b1;
                    state_n      = LOAD;
                end
            end
            LOAD: begin
                if (bus.clr || !bus.req[sel]) begin
                    gnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    q_n        = bus.data[int'(sel)*W +: W];
                    q_valid_n  = 1'b1;
                    ack_n      = '0;
                    ack_n[sel] = 1'b1;
                    state_n    = ACK;
                end
            end
            ACK: begin
                ack_n   = '0;
                gnt_n   = '0;
                ptr_n   = PW'((int'(sel) + 1) % N);
                state_n = IDLE;
            end
            default: begin
                gnt_n   = '0;
                ack_n   = '0;
                state_n = IDLE;
            end
        endcase
        // Clear overrides any load in the same cycle, in every state.
        if (bus.clr) begin
            q_n       = '0;
            q_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            sel     <= '0;
            gnt     <= '0;
            ack     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            sel     <= sel_n;
            gnt     <= gnt_n;
            ack     <= ack_n;
            q       <= q_n;
            q_valid <= q_valid_n;
        end
    end

    assign bus.gnt     = gnt;
    assign bus.ack     = ack;
    assign bus.q       = q;
    assign bus.q_valid = q_valid;
    assign bus.busy    = (state != IDLE);
    assign state_dbg   = state;
endmodule
